// File: rtl/press_classifier_if.sv
// Debounced edge pulses in, gesture events and status levels out.
interface press_classifier_if;
  logic i_pos;
  logic i_neg;
  logic o_short;
  logic o_long;
  logic o_double;
  logic o_hold;
  logic o_busy;

  modport master (output i_pos, i_neg,
                  input  o_short, o_long, o_double, o_hold, o_busy);
  modport slave  (input  i_pos, i_neg,
                  output o_short, o_long, o_double, o_hold, o_busy);
endinterface

// File: rtl/press_classifier.sv
// Classifies button gestures (short / long / double click) from debounced
// rise/fall pulses; one registered event pulse per gesture.
module press_classifier #(
  parameter int LONG_CYC = 8,
  parameter int DBL_GAP  = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  press_classifier_if.slave bus
);
  localparam int MAX_CYC = (LONG_CYC > DBL_GAP) ? LONG_CYC : DBL_GAP;
  localparam int CNT_BIT = $clog2(MAX_CYC);
  localparam logic [CNT_BIT-1:0] LONG_LAST = CNT_BIT'(LONG_CYC - 1);
  localparam logic [CNT_BIT-1:0] GAP_LAST  = CNT_BIT'(DBL_GAP - 1);

  typedef enum logic [2:0] {IDLE, PRESS, HELD, GAP, WAIT_REL} state_e;

  state_e             state_q, state_d;
  logic [CNT_BIT-1:0] cnt_q, cnt_d;
  logic               short_q, short_d;
  logic               long_q, long_d;
  logic               double_q, double_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      short_q  <= short_d;
      long_q   <= long_d;
      double_q <= double_d;
    end
  end

  // Release beats long timeout in PRESS; second press beats gap timeout in GAP.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      IDLE:     if (bus.i_pos) state_d = PRESS;
      PRESS: begin
        cnt_d = cnt_q + CNT_BIT'(1);
        if (bus.i_neg) begin
          state_d = GAP;
          cnt_d   = '0;
        end else if (cnt_q == LONG_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
        end
      end
      HELD:     if (bus.i_neg) state_d = IDLE;
      GAP: begin
        cnt_d = cnt_q + CNT_BIT'(1);
        if (bus.i_pos) begin
          state_d = WAIT_REL;
          cnt_d   = '0;
        end else if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      WAIT_REL: if (bus.i_neg) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    long_d   = (state_q == PRESS) && !bus.i_neg && (cnt_q == LONG_LAST);
    short_d  = (state_q == GAP)   && !bus.i_pos && (cnt_q == GAP_LAST);
    double_d = (state_q == GAP)   &&  bus.i_pos;
  end

  assign bus.o_short  = short_q;
  assign bus.o_long   = long_q;
  assign bus.o_double = double_q;
  assign bus.o_hold   = (state_q == HELD);
  assign bus.o_busy   = (state_q != IDLE);
endmodule

// File: tb/tb_press_classifier.sv
// Directed gesture vectors: per-cycle input masks and expected output masks.
module tb_press_classifier;
  logic clk = 1'b0;
  logic rst;
  press_classifier_if bus ();

  press_classifier #(.LONG_CYC(8), .DBL_GAP(5)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] rst_m, pos_m, neg_m;
    logic [63:0] short_m, long_m, dbl_m, hold_m, busy_m;
  } vec_t;

  localparam int NVEC = 11;
  localparam int LAST = 47;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc;
  vec_t tbl [NVEC];

  function automatic logic [63:0] rng(input int a, input int b);
    logic [63:0] m;
    m = '0;
    for (int i = a; i <= b; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] bt(input int n);
    return rng(n, n);
  endfunction

  task automatic chk(input string nm, input int c, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %b, expected %b", nm, c, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic p, input logic n);
    @(negedge clk);
    cyc++;
    rst       = r;
    bus.i_pos = p;
    bus.i_neg = n;
  endtask

  function automatic vec_t mk(input string nm, input logic [63:0] r, p, n,
                              input logic [63:0] s, l, d, h, b);
    vec_t v;
    v.name = nm; v.rst_m = r; v.pos_m = p; v.neg_m = n;
    v.short_m = s; v.long_m = l; v.dbl_m = d; v.hold_m = h; v.busy_m = b;
    return v;
  endfunction

  initial begin
    logic [63:0] r0, z;
    rst = 1'b1; bus.i_pos = 1'b0; bus.i_neg = 1'b0;
    r0 = rng(1, 2);
    z  = '0;
    //              name        rst              pos                neg                       short               long     dbl      hold           busy
    tbl[0]  = mk("short",     r0,             bt(10),            bt(3)|bt(13),             bt(19),             z,       z,       z,             rng(11,18));
    tbl[1]  = mk("long",      r0,             bt(10),            bt(3)|bt(30),             z,                  bt(19),  z,       rng(19,30),    rng(11,30));
    tbl[2]  = mk("bnd_short", r0,             bt(10),            bt(3)|bt(18),             bt(24),             z,       z,       z,             rng(11,23));
    tbl[3]  = mk("bnd_long",  r0,             bt(10),            bt(3)|bt(19),             z,                  bt(19),  z,       bt(19),        rng(11,19));
    tbl[4]  = mk("double",    r0,             bt(10)|bt(17),     bt(3)|bt(12)|bt(40),      z,                  z,       bt(18),  z,             rng(11,40));
    tbl[5]  = mk("late_2nd",  r0,             bt(10)|bt(18),     bt(3)|bt(12)|bt(20),      bt(18)|bt(26),      z,       z,       z,             rng(11,17)|rng(19,25));
    tbl[6]  = mk("rst_mid",   r0|bt(14),      bt(10),            bt(3)|bt(16),             z,                  z,       z,       z,             rng(11,14));
    tbl[7]  = mk("rst_pend",  r0|bt(18),      bt(10),            bt(3)|bt(13),             z,                  z,       z,       z,             rng(11,18));
    tbl[8]  = mk("sim_gap",   r0,             bt(10)|bt(17),     bt(3)|bt(12)|bt(17)|bt(25), z,                z,       bt(18),  z,             rng(11,25));
    tbl[9]  = mk("sim_idle",  r0,             bt(10),            bt(3)|bt(10)|bt(13),      bt(19),             z,       z,       z,             rng(11,18));
    tbl[10] = mk("pos_press", r0,             bt(10)|bt(12),     bt(3)|bt(14),             bt(20),             z,       z,       z,             rng(11,19));

    for (int v = 0; v < NVEC; v++) begin
      cyc = 0;
      for (int c = 1; c <= LAST; c++) begin
        step(tbl[v].rst_m[c], tbl[v].pos_m[c], tbl[v].neg_m[c]);
        if (c >= 2) begin
          chk({tbl[v].name, ".short"},  c, bus.o_short,  tbl[v].short_m[c]);
          chk({tbl[v].name, ".long"},   c, bus.o_long,   tbl[v].long_m[c]);
          chk({tbl[v].name, ".double"}, c, bus.o_double, tbl[v].dbl_m[c]);
          chk({tbl[v].name, ".hold"},   c, bus.o_hold,   tbl[v].hold_m[c]);
          chk({tbl[v].name, ".busy"},   c, bus.o_busy,   tbl[v].busy_m[c]);
        end
      end
    end

    // Press arriving together with reset is dropped; then a tight double click.
    cyc = 0;
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk("hs.busy_after_rst", cyc, bus.o_busy, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk("hs.busy_press", cyc, bus.o_busy, 1'b1);
    chk("hs.hold_press", cyc, bus.o_hold, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("hs.no_dbl_yet", cyc, bus.o_double, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk("hs.double", cyc, bus.o_double, 1'b1);
    chk("hs.busy_wait", cyc, bus.o_busy, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk("hs.double_off", cyc, bus.o_double, 1'b0);
    chk("hs.idle", cyc, bus.o_busy, 1'b0);
    chk("hs.no_short", cyc, bus.o_short, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/press_classifier.md
Name: press_classifier

Overview:
Consumes the single-cycle rise and fall pulses from the button debouncer. It classifies each button gesture as a short press, a long press or a double click. For each gesture it emits one registered single-cycle event pulse, plus hold and busy levels, for the downstream control logic (mode select, counters, display).

Parameters:
LONG_CYC, 8, press length in cycles (pos-to-neg distance) above which a press is long; legal range ≥2
DBL_GAP, 5, max release-to-next-press distance in cycles that still counts as a double click; legal range ≥2
(local) CNT_BIT = $clog2(max(LONG_CYC, DBL_GAP)); width of the internal counter

Ports:
i_clk     input   1  clock
i_rst     input   1  reset; synchronous, active-high
i_pos     input   1  debounced rising-edge pulse; single cycle
i_neg     input   1  debounced falling-edge pulse; single cycle
o_short   output  1  single-cycle pulse: short press, no second press followed
o_long    output  1  single-cycle pulse: press held past LONG_CYC
o_double  output  1  single-cycle pulse: second press arrived within DBL_GAP
o_hold    output  1  level; high while in HELD
o_busy    output  1  level; high while state != IDLE

Behaviour:
- One clock, i_clk. Reset is synchronous and active-high on i_rst.
- While i_rst is sampled high:
  - state <= IDLE, cnt <= 0.
  - All outputs are 0 from the next cycle.
  - Reset mid-gesture abandons the gesture and emits no pulse.
- All outputs are registered. Event pulses last exactly 1 cycle.
- States: IDLE, PRESS, HELD, GAP, WAIT_REL. Encoding is free.
- IDLE:
  - i_pos -> PRESS, cnt <= 0.
  - i_neg is ignored (e.g. the release that follows a reset).
- PRESS: cnt increments each cycle.
  - i_neg -> GAP, cnt <= 0.
  - else if cnt == LONG_CYC-1 -> HELD, o_long <= 1.
  - i_neg wins over timeout in the same cycle.
- HELD: o_hold = 1, cnt held 0.
  - i_neg -> IDLE. No further pulse.
- GAP: cnt increments each cycle.
  - i_pos -> WAIT_REL, o_double <= 1, cnt <= 0.
  - else if cnt == DBL_GAP-1 -> IDLE, o_short <= 1.
  - i_pos wins over timeout in the same cycle.
- WAIT_REL: cnt held 0; long-hold detection is disabled.
  - i_neg -> IDLE. No further pulse.
- Pulses that are irrelevant to the current state are ignored:
  - i_pos in PRESS, HELD or WAIT_REL.
  - i_neg in IDLE or GAP.
- Simultaneous i_pos and i_neg: only the pulse relevant to the current state acts.
- Timing, with i_pos sampled at cycle k:
  - PRESS is entered at k+1 with cnt=0.
  - i_neg at cycle k+d with d ≤ LONG_CYC gives a short or double path.
  - With no i_neg, o_long is high at cycle k+LONG_CYC+1.
- Timing, with i_neg sampled at cycle m (from PRESS):
  - i_pos at cycle ≤ m+DBL_GAP gives o_double at i_pos cycle+1.
  - Otherwise o_short is high at m+DBL_GAP+1.
- o_hold and o_busy are decoded from the registered state, so they carry no extra latency.
- A double click emits only o_double; no o_short precedes it.
- A long press emits only o_long.
- cnt never wraps: every counting state leaves on its terminal count.

Test Plan:
- Setup: LONG_CYC=8, DBL_GAP=5. Release/reset check: pulse i_rst 2 cycles, then i_neg at cycle 3 -> all outputs stay 0, o_busy 0.
- Short press:
  - i_pos at 10, i_neg at 13 -> o_short=1 at cycle 19 only.
  - o_busy high for cycles 11–18; o_long and o_double never assert.
- Long press:
  - i_pos at 10, no i_neg -> o_long=1 at cycle 19 only; o_hold high from 19.
  - i_neg at 30 -> o_hold and o_busy low at 31; no o_short.
- Press length at the boundary (i_pos at 10):
  - i_neg at 18 -> short path taken; o_short at 24.
  - i_neg at 19 -> o_long at 19.
- Double click:
  - i_pos 10, i_neg 12, i_pos 17 -> o_double=1 at 18; no o_short.
  - Holding past 8 more cycles gives no o_long; i_neg at 40 -> idle at 41.
  - Variant i_pos at 18 -> o_short at 18, no o_double; a new PRESS starts from IDLE only if i_pos arrives at ≥18 while in IDLE.
- Reset mid-gesture:
  - i_pos 10, i_rst high at 14 -> no pulses ever.
  - o_busy 0 at 15; subsequent i_neg at 16 ignored.
